// File: rtl/wb_stream_reader_ctrl_if.sv
// Wishbone B3 master-side bus bundle for the stream reader write path.
// A master modport for the controller and a slave modport for the bus side.
interface wb_stream_reader_ctrl_if #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
);
    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW-1:0]   wbm_dat_o;
    logic [WB_DW/8-1:0] wbm_sel_o;
    logic               wbm_we_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic [2:0]         wbm_cti_o;
    logic [1:0]         wbm_bte_o;
    logic [WB_DW-1:0]   wbm_dat_i;
    logic               wbm_ack_i;
    logic               wbm_err_i;
    logic               wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/wb_stream_reader_ctrl.sv
// Drains a FWFT FIFO into a circular memory buffer using Wishbone incrementing
// write bursts; pulses irq on every buffer wrap.
module wb_stream_reader_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_stream_reader_ctrl_if.master wbm,
    input  logic [WB_DW-1:0]       fifo_dout,
    output logic                   fifo_rd,
    input  logic [FIFO_AW:0]       fifo_cnt,
    input  logic                   enable,
    input  logic [WB_AW-1:0]       start_adr,
    input  logic [WB_AW-1:0]       buf_size,
    input  logic [WB_AW-1:0]       burst_size,
    output logic                   busy,
    output logic                   irq,
    output logic                   err
);
    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam logic [WB_AW-1:0] BYTES  = WB_AW'(WB_DW/8);
    localparam logic [WB_AW-1:0] MAX_BL = WB_AW'(MAX_BURST_LEN);
    localparam logic [WB_AW-1:0] ONE    = WB_AW'(1);

    state_t           r_state;
    logic [WB_AW-1:0] r_idx;
    logic [WB_AW-1:0] r_bcnt;
    logic             r_cyc;
    logic             r_irq;
    logic             r_err;
    logic             r_en_q;

    logic [WB_AW-1:0] w_bsize, w_breq, w_bclamp, w_idx_cur, w_room, w_blen, w_idx_inc;
    logic             w_en_rise, w_start, w_wrap, w_unused;

    // A rising enable restarts at the buffer base, including the start decision made that cycle.
    assign w_en_rise = enable & ~r_en_q;
    assign w_idx_cur = w_en_rise ? '0 : r_idx;

    assign w_bsize   = (buf_size == '0) ? ONE : buf_size;
    assign w_breq    = (burst_size == '0) ? ONE : burst_size;
    assign w_bclamp  = (w_breq > MAX_BL) ? MAX_BL : w_breq;
    assign w_room    = (w_idx_cur < w_bsize) ? (w_bsize - w_idx_cur) : ONE;
    assign w_blen    = (w_bclamp < w_room) ? w_bclamp : w_room;
    assign w_start   = enable & ~r_err & (WB_AW'(fifo_cnt) >= w_blen);

    assign w_idx_inc = r_idx + ONE;
    assign w_wrap    = (w_idx_inc >= w_bsize);

    assign wbm.wbm_adr_o = start_adr + r_idx * BYTES;
    assign wbm.wbm_dat_o = fifo_dout;
    assign wbm.wbm_sel_o = '1;
    assign wbm.wbm_we_o  = 1'b1;
    assign wbm.wbm_cyc_o = r_cyc;
    assign wbm.wbm_stb_o = r_cyc;
    assign wbm.wbm_cti_o = r_cyc ? ((r_bcnt == ONE) ? 3'b111 : 3'b010) : 3'b000;
    assign wbm.wbm_bte_o = 2'b00;

    assign fifo_rd = r_cyc & wbm.wbm_ack_i;
    assign busy    = (r_state == S_BURST);
    assign irq     = r_irq;
    assign err     = r_err;
    assign w_unused = ^wbm.wbm_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_cyc   <= 1'b0;
            r_irq   <= 1'b0;
            r_err   <= 1'b0;
            r_en_q  <= 1'b0;
        end else begin
            r_en_q <= enable;
            r_irq  <= 1'b0;
            if (!enable)   r_err <= 1'b0;
            if (w_en_rise) r_idx <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_BURST;
                        r_cyc   <= 1'b1;
                        r_bcnt  <= w_blen;
                    end
                end
                S_BURST: begin
                    // Ack beats err/rty; a dropped cyc inside BURST is the one-cycle retry gap.
                    if (!r_cyc) begin
                        r_cyc <= 1'b1;
                    end else if (wbm.wbm_ack_i) begin
                        r_idx  <= w_wrap ? '0 : w_idx_inc;
                        r_irq  <= w_wrap;
                        r_bcnt <= r_bcnt - ONE;
                        if (r_bcnt == ONE) begin
                            r_cyc   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (wbm.wbm_err_i) begin
                        r_cyc   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (wbm.wbm_rty_i) begin
                        r_cyc <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Bench for wb_stream_reader_ctrl: FIFO model, scripted slave and a beat scoreboard.
module tb_wb_stream_reader_ctrl;
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] start_adr, buf_size, burst_size;
    logic        fifo_rd, busy, irq, err;
    logic [31:0] fifo_dout;
    logic [4:0]  fifo_cnt;

    logic [31:0] mem [16];
    logic [4:0]  wr_ptr = '0;
    logic [4:0]  rd_ptr = '0;

    int checks = 0;
    int errors = 0;
    int acks = 0, irq_cnt = 0, irq_ack = 0, gaps = 0;
    int inj_id = 0, inj_done_id = 0, inj_at = 0, inj_kind = 0;
    logic hit;
    beat_t sb[$];

    always #5 clk = ~clk;

    wb_stream_reader_ctrl_if #(.WB_AW(32), .WB_DW(32)) wbm ();

    wb_stream_reader_ctrl #(.WB_AW(32), .WB_DW(32), .FIFO_AW(4), .MAX_BURST_LEN(16)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbm(wbm),
        .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .fifo_cnt(fifo_cnt),
        .enable(enable), .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
        .busy(busy), .irq(irq), .err(err)
    );

    assign fifo_dout = mem[rd_ptr[3:0]];
    assign fifo_cnt  = wr_ptr - rd_ptr;
    assign wbm.wbm_dat_i = '0;

    // Slave: zero-wait acks, except one scripted rty/err on a chosen beat.
    always_comb begin
        hit = (inj_kind != 0) && (inj_done_id != inj_id) && (acks == inj_at);
        wbm.wbm_ack_i = wbm.wbm_cyc_o & wbm.wbm_stb_o & ~hit;
        wbm.wbm_rty_i = wbm.wbm_cyc_o & wbm.wbm_stb_o & hit & (inj_kind == 1);
        wbm.wbm_err_i = wbm.wbm_cyc_o & wbm.wbm_stb_o & hit & (inj_kind == 2);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (fifo_rd) rd_ptr <= rd_ptr + 5'd1;
        if (wbm.wbm_cyc_o && wbm.wbm_stb_o && wbm.wbm_ack_i) acks <= acks + 1;
        if (hit && wbm.wbm_cyc_o && wbm.wbm_stb_o) inj_done_id <= inj_id;
    end

    always @(negedge clk) begin
        beat_t e;
        if (irq) begin
            irq_cnt <= irq_cnt + 1;
            irq_ack <= acks;
        end
        if (busy && !wbm.wbm_cyc_o) gaps <= gaps + 1;
        if (wbm.wbm_cyc_o || fifo_rd)
            chk("pop_rule", fifo_rd, wbm.wbm_cyc_o & wbm.wbm_stb_o & wbm.wbm_ack_i);
        if (wbm.wbm_cyc_o && wbm.wbm_stb_o && wbm.wbm_ack_i) begin
            chk("underrun", fifo_cnt != 0, 1);
            chk("attr", {wbm.wbm_we_o, wbm.wbm_sel_o, wbm.wbm_bte_o}, {1'b1, 4'hF, 2'b00});
            if (sb.size() == 0) begin
                chk("sb_extra_beat", wbm.wbm_adr_o, 64'hFFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("adr", wbm.wbm_adr_o, e.adr);
                chk("dat", wbm.wbm_dat_o, e.dat);
                chk("cti", wbm.wbm_cti_o, e.cti);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        beat_t b;
        b.adr = a; b.dat = d; b.cti = c;
        sb.push_back(b);
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] a, input logic [2:0] c, input bit ex);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 5'd1;
        if (ex) sb_push(a, d, c);
    endtask

    task automatic wait_done(input int n);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (sb.size() == 0 && !busy && !wbm.wbm_cyc_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("timeout", ok, 1);
        repeat (2) tick();
    endtask

    task automatic restart(input logic [31:0] bsz);
        enable = 1'b0;
        tick();
        buf_size = bsz;
        enable = 1'b1;
    endtask

    initial begin
        int b0, i0, g0;
        logic [4:0] r0;
        rst_n = 1'b0; enable = 1'b0;
        start_adr = 32'h1000; buf_size = 32'd8; burst_size = 32'd4;
        repeat (3) tick();
        chk("rst_cyc", wbm.wbm_cyc_o, 0);
        chk("rst_cti", wbm.wbm_cti_o, 0);
        chk("rst_flags", {busy, irq, err, fifo_rd}, 0);
        chk("rst_adr", wbm.wbm_adr_o, 32'h1000);
        rst_n = 1'b1;
        tick();

        // Two 4-beat bursts over an 8-word buffer
        b0 = acks; i0 = irq_cnt; r0 = rd_ptr;
        for (int i = 0; i < 8; i++)
            push(32'hA0 + i, 32'h1000 + 4*i, (i % 4 == 3) ? 3'b111 : 3'b010, 1);
        enable = 1'b1;
        wait_done(200);
        chk("b_pops", 5'(rd_ptr - r0), 8);
        chk("b_irq_cnt", irq_cnt - i0, 1);
        chk("b_irq_at", irq_ack - b0, 8);

        // Threshold: 3 words never start a 4-beat burst
        for (int i = 0; i < 3; i++)
            push(32'hB0 + i, 32'h1000 + 4*i, 3'b010, 1);
        repeat (5) tick();
        chk("thr_idle", wbm.wbm_cyc_o, 0);
        push(32'hB3, 32'h100C, 3'b111, 1);
        @(negedge clk);
        chk("thr_cyc_early", wbm.wbm_cyc_o, 0);
        @(negedge clk);
        chk("thr_cyc", wbm.wbm_cyc_o, 1);
        wait_done(100);

        // Truncated tail: 4 + 2 over a 6-word buffer
        restart(32'd6);
        b0 = acks; i0 = irq_cnt; r0 = rd_ptr;
        for (int i = 0; i < 6; i++)
            push(32'hC0 + i, 32'h1000 + 4*i, (i == 3 || i == 5) ? 3'b111 : 3'b010, 1);
        wait_done(200);
        chk("t_pops", 5'(rd_ptr - r0), 6);
        chk("t_irq_cnt", irq_cnt - i0, 1);
        chk("t_irq_at", irq_ack - b0, 6);
        chk("t_wrap_adr", wbm.wbm_adr_o, 32'h1000);

        // Retry on beat 2
        restart(32'd8);
        b0 = acks; g0 = gaps; r0 = rd_ptr;
        inj_kind = 1; inj_at = b0 + 1; inj_id++;
        for (int i = 0; i < 4; i++)
            push(32'hD0 + i, 32'h1000 + 4*i, (i == 3) ? 3'b111 : 3'b010, 1);
        push(32'hD4, 0, 0, 0);
        wait_done(100);
        chk("r_fired", inj_done_id, inj_id);
        chk("r_gap", gaps - g0, 1);
        chk("r_pops", 5'(rd_ptr - r0), 4);
        chk("r_left", fifo_cnt, 1);
        enable = 1'b0;
        tick();
        wr_ptr = rd_ptr;

        // Error on beat 3
        enable = 1'b1;
        tick();
        b0 = acks; r0 = rd_ptr;
        inj_kind = 2; inj_at = b0 + 2; inj_id++;
        for (int i = 0; i < 5; i++)
            push(32'hE0 + i, 32'h1000 + 4*i, 3'b010, i < 2);
        wait_done(100);
        chk("e_flag", err, 1);
        chk("e_pops", 5'(rd_ptr - r0), 2);
        push(32'hF0, 0, 0, 0);
        push(32'hF1, 0, 0, 0);
        repeat (10) tick();
        chk("e_stall_acks", acks - b0, 2);
        chk("e_stall_busy", {busy, wbm.wbm_cyc_o}, 0);
        enable = 1'b0;
        tick();
        chk("e_clear", err, 0);
        sb_push(32'h1000, 32'hE2, 3'b010);
        sb_push(32'h1004, 32'hE3, 3'b010);
        sb_push(32'h1008, 32'hE4, 3'b010);
        sb_push(32'h100C, 32'hF0, 3'b111);
        enable = 1'b1;
        wait_done(100);
        chk("e_restart_err", err, 0);

        // Reset during beat 2
        enable = 1'b0;
        tick();
        wr_ptr = rd_ptr;
        enable = 1'b1;
        b0 = acks; r0 = rd_ptr;
        push(32'h60, 32'h1000, 3'b010, 1);
        push(32'h61, 32'h1004, 3'b010, 1);
        push(32'h62, 0, 0, 0);
        push(32'h63, 0, 0, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
                tick();
                if (wbm.wbm_cyc_o && acks == b0 + 1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("x_reach_beat2", seen, 1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("x_cyc", wbm.wbm_cyc_o, 0);
        chk("x_flags", {fifo_rd, irq, busy}, 0);
        chk("x_adr", wbm.wbm_adr_o, 32'h1000);
        repeat (3) tick();
        chk("x_pops", 5'(rd_ptr - r0), 2);
        rst_n = 1'b1;
        tick();
        chk("sb_left", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
